// File: rtl/serial_logic_pkg.sv
// rtl/serial_logic_pkg.sv - opcodes, FSM states and default width for the bit-serial logic unit
package serial_logic_pkg;

    localparam int DEFAULT_WIDTH = 16;

    localparam logic [3:1] OP_NOT  = 3'b000;
    localparam logic [3:1] OP_AND  = 3'b001;
    localparam logic [3:1] OP_OR   = 3'b010;
    localparam logic [3:1] OP_XOR  = 3'b011;
    localparam logic [3:1] OP_NAND = 3'b100;
    localparam logic [3:1] OP_NOR  = 3'b101;
    localparam logic [3:1] OP_XNOR = 3'b110;
    localparam logic [3:1] OP_PASS = 3'b111;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_e;

endpackage

// File: rtl/serial_logic_unit_if.sv
// rtl/serial_logic_unit_if.sv - start/done bus of the serial logic unit; SERIAL_LOGIC_FLAGS_EN adds zero/parity
interface serial_logic_unit_if #(parameter int WIDTH = 16);

    logic [WIDTH:1] A;
    logic [WIDTH:1] B;
    logic [3:1]     op;
    logic           start;
    logic           busy;
    logic           done;
    logic [WIDTH:1] out;
`ifdef SERIAL_LOGIC_FLAGS_EN
    logic           zero;
    logic           parity;

    modport master (output A, B, op, start, input busy, done, out, zero, parity);
    modport slave  (input A, B, op, start, output busy, done, out, zero, parity);
`else
    modport master (output A, B, op, start, input busy, done, out);
    modport slave  (input A, B, op, start, output busy, done, out);
`endif

endinterface

// File: rtl/serial_logic_bit.sv
// rtl/serial_logic_bit.sv - one-bit combinational evaluation of the eight logic opcodes
module serial_logic_bit
    import serial_logic_pkg::*;
(
    input  logic       a,
    input  logic       b,
    input  logic [3:1] op,
    output logic       y
);

    always_comb begin
        y = 1'b0;
        case (op)
            OP_NOT:  y = ~a;
            OP_AND:  y = a & b;
            OP_OR:   y = a | b;
            OP_XOR:  y = a ^ b;
            OP_NAND: y = ~(a & b);
            OP_NOR:  y = ~(a | b);
            OP_XNOR: y = ~(a ^ b);
            OP_PASS: y = a;
            default: y = 1'b0;
        endcase
    end

endmodule

// File: rtl/serial_logic_unit.sv
// rtl/serial_logic_unit.sv - bit-serial logic engine, one result bit per clock; SERIAL_LOGIC_FLAGS_EN adds zero/parity flags
module serial_logic_unit
    import serial_logic_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic                clk,
    input  logic                rst,
    serial_logic_unit_if.slave  bus
);

    localparam int CW = $clog2(WIDTH + 1);

    state_e         state_q;
    logic [CW-1:0]  count_q;
    logic [WIDTH:1] a_q;
    logic [WIDTH:1] b_q;
    logic [3:1]     op_q;
    logic [WIDTH:1] work_q;
    logic [WIDTH:1] work_d;
    logic [WIDTH:1] out_q;
    logic           busy_q;
    logic           done_q;
    logic           bit_y;
`ifdef SERIAL_LOGIC_FLAGS_EN
    logic           zero_q;
    logic           parity_q;
`endif

    serial_logic_bit u_bit (
        .a  (a_q[count_q]),
        .b  (b_q[count_q]),
        .op (op_q),
        .y  (bit_y)
    );

    // work_d includes the bit evaluated this cycle, so the final edge can load out directly
    always_comb begin
        work_d = work_q;
        if (state_q == S_RUN) begin
            work_d[count_q] = bit_y;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            count_q  <= '0;
            a_q      <= '0;
            b_q      <= '0;
            op_q     <= '0;
            work_q   <= '0;
            out_q    <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
`ifdef SERIAL_LOGIC_FLAGS_EN
            zero_q   <= 1'b1;
            parity_q <= 1'b0;
`endif
        end else begin
            case (state_q)
                S_IDLE, S_DONE: begin
                    done_q <= 1'b0;
                    if (bus.start) begin
                        a_q     <= bus.A;
                        b_q     <= bus.B;
                        op_q    <= bus.op;
                        work_q  <= '0;
                        count_q <= CW'(1);
                        busy_q  <= 1'b1;
                        state_q <= S_RUN;
                    end else begin
                        state_q <= S_IDLE;
                    end
                end
                S_RUN: begin
                    work_q <= work_d;
                    if (count_q == CW'(WIDTH)) begin
                        out_q    <= work_d;
`ifdef SERIAL_LOGIC_FLAGS_EN
                        zero_q   <= ~|work_d;
                        parity_q <= ^work_d;
`endif
                        count_q  <= '0;
                        busy_q   <= 1'b0;
                        done_q   <= 1'b1;
                        state_q  <= S_DONE;
                    end else begin
                        count_q <= count_q + CW'(1);
                    end
                end
                default: begin
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.busy   = busy_q;
    assign bus.done   = done_q;
    assign bus.out    = out_q;
`ifdef SERIAL_LOGIC_FLAGS_EN
    assign bus.zero   = zero_q;
    assign bus.parity = parity_q;
`endif

endmodule
